pong_score_ctrl: RTL and testbench

PONG_SCORE_CTRL -- requirements
Module: pong_score_ctrl

---
 rtl/pong_score_ctrl_if.sv | 41 ++++
 rtl/pong_score_ctrl.sv | 160 ++++++++++++++++
 tb/tb_pong_score_ctrl.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pong_score_ctrl_if.sv
// Purpose: groups the handshake and status signals between the Pong ball
// stage / user input and the score controller.
// Signals:
//   in_ani_stb       one-cycle animation strobe, once per frame
//   in_left_score    sticky flag, left player has just scored
//   in_right_score   sticky flag, right player has just scored
//   in_serve         serve/restart button level (synchronised, debounced)
//   out_start        one-cycle pulse starting a ball round
//   out_ball_reset   one-cycle pulse re-centring the ball
//   out_left_points  left score
//   out_right_points right score
//   out_game_over    high while the game is over
//   out_winner       0 = left, 1 = right; valid while out_game_over = 1
//   out_state        current controller state code
// Modports: master drives the inputs and observes the outputs; slave is the
// controller side.
interface pong_score_ctrl_if;
    logic       in_ani_stb;
    logic       in_left_score;
    logic       in_right_score;
    logic       in_serve;
    logic       out_start;
    logic       out_ball_reset;
    logic [3:0] out_left_points;
    logic [3:0] out_right_points;
    logic       out_game_over;
    logic       out_winner;
    logic [2:0] out_state;

    modport master (
        output in_ani_stb, in_left_score, in_right_score, in_serve,
        input  out_start, out_ball_reset, out_left_points, out_right_points,
               out_game_over, out_winner, out_state
    );

    modport slave (
        input  in_ani_stb, in_left_score, in_right_score, in_serve,
        output out_start, out_ball_reset, out_left_points, out_right_points,
               out_game_over, out_winner, out_state
    );
endinterface

// File: rtl/pong_score_ctrl.sv
// Purpose: Pong game sequencing -- serve, scoring, inter-point delay and
// game-over handling.
// Ports:
//   in_clock   single clock for all logic
//   in_reset   synchronous, active-high reset
//   ctrl       pong_score_ctrl_if.slave bundle (strobe, score flags, serve
//              button in; start/ball-reset pulses, scores, game status out)
// Parameters:
//   WIN_POINTS   points that end a game (1..15)
//   SERVE_DELAY  animation strobes between a point and the next serve (1..255)
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for a serve button press
// SERVE  | issue the one-cycle start pulse, then play
// PLAY   | ball in flight, watching for a score edge
// DELAY  | counting animation strobes before the next serve
// OVER   | a player reached WIN_POINTS; scores and winner frozen
module pong_score_ctrl #(
    parameter int WIN_POINTS  = 5,
    parameter int SERVE_DELAY = 120
) (
    input logic               in_clock,
    input logic               in_reset,
    pong_score_ctrl_if.slave  ctrl
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_DELAY = 3'd3,
        ST_OVER  = 3'd4
    } state_t;

    localparam logic [3:0] WIN_L   = 4'(WIN_POINTS);
    localparam logic [7:0] DELAY_L = 8'(SERVE_DELAY);

    state_t     state_q;
    logic [3:0] left_pts_q;
    logic [3:0] right_pts_q;
    logic [7:0] delay_cnt_q;
    logic       start_q;
    logic       ball_reset_q;
    logic       boot_pulse_q;
    logic       winner_q;
    logic       serve_q;
    logic       left_q;
    logic       right_q;

    logic       serve_rise;
    logic       left_rise;
    logic       right_rise;
    logic [3:0] left_pts_d;
    logic [3:0] right_pts_d;

    assign serve_rise  = ctrl.in_serve       & ~serve_q;
    assign left_rise   = ctrl.in_left_score  & ~left_q;
    assign right_rise  = ctrl.in_right_score & ~right_q;
    assign left_pts_d  = left_pts_q  + 4'd1;
    assign right_pts_d = right_pts_q + 4'd1;

    always_ff @(posedge in_clock) begin
        if (in_reset) begin
            state_q      <= ST_IDLE;
            left_pts_q   <= 4'd0;
            right_pts_q  <= 4'd0;
            delay_cnt_q  <= 8'd0;
            start_q      <= 1'b0;
            ball_reset_q <= 1'b0;
            boot_pulse_q <= 1'b1;
            winner_q     <= 1'b0;
            // Track live levels so anything held through reset is not an edge.
            serve_q      <= ctrl.in_serve;
            left_q       <= ctrl.in_left_score;
            right_q      <= ctrl.in_right_score;
        end else begin
            serve_q      <= ctrl.in_serve;
            left_q       <= ctrl.in_left_score;
            right_q      <= ctrl.in_right_score;
            start_q      <= 1'b0;
            // Re-centre the ball once on the first cycle out of reset.
            ball_reset_q <= boot_pulse_q;
            boot_pulse_q <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (serve_rise) begin
                        state_q <= ST_SERVE;
                    end
                end

                ST_SERVE: begin
                    start_q <= 1'b1;
                    state_q <= ST_PLAY;
                end

                ST_PLAY: begin
                    // Left wins a tie between simultaneous edges.
                    if (left_rise) begin
                        if (left_pts_q < WIN_L) begin
                            left_pts_q <= left_pts_d;
                        end
                        if (left_pts_d == WIN_L) begin
                            winner_q <= 1'b0;
                            state_q  <= ST_OVER;
                        end else begin
                            delay_cnt_q <= DELAY_L;
                            state_q     <= ST_DELAY;
                        end
                    end else if (right_rise) begin
                        if (right_pts_q < WIN_L) begin
                            right_pts_q <= right_pts_d;
                        end
                        if (right_pts_d == WIN_L) begin
                            winner_q <= 1'b1;
                            state_q  <= ST_OVER;
                        end else begin
                            delay_cnt_q <= DELAY_L;
                            state_q     <= ST_DELAY;
                        end
                    end
                end

                ST_DELAY: begin
                    if (ctrl.in_ani_stb) begin
                        if (delay_cnt_q <= 8'd1) begin
                            delay_cnt_q <= 8'd0;
                            state_q     <= ST_SERVE;
                        end else begin
                            delay_cnt_q <= delay_cnt_q - 8'd1;
                        end
                    end
                end

                ST_OVER: begin
                    if (serve_rise) begin
                        left_pts_q   <= 4'd0;
                        right_pts_q  <= 4'd0;
                        ball_reset_q <= 1'b1;
                        state_q      <= ST_IDLE;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign ctrl.out_start        = start_q;
    assign ctrl.out_ball_reset   = ball_reset_q;
    assign ctrl.out_left_points  = left_pts_q;
    assign ctrl.out_right_points = right_pts_q;
    assign ctrl.out_game_over    = (state_q == ST_OVER);
    assign ctrl.out_winner       = winner_q;
    assign ctrl.out_state        = state_q;

endmodule

// File: tb/tb_pong_score_ctrl.sv
module tb_pong_score_ctrl;

    localparam int WIN  = 5;
    localparam int SDLY = 120;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pong_score_ctrl_if bus ();

    pong_score_ctrl #(
        .WIN_POINTS  (WIN),
        .SERVE_DELAY (SDLY)
    ) dut (
        .in_clock (clk),
        .in_reset (rst),
        .ctrl     (bus)
    );

    int tests = 0;
    int fails = 0;

    // expected scores, kept as plain game-level counts
    int exp_l = 0;
    int exp_r = 0;

    // pulse monitor
    int start_cnt = 0;
    int br_cnt    = 0;
    int both_cnt  = 0;
    int wide_cnt  = 0;
    logic prev_start = 1'b0;
    logic prev_br    = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.out_start === 1'b1) start_cnt++;
            if (bus.out_ball_reset === 1'b1) br_cnt++;
            if (bus.out_start === 1'b1 && bus.out_ball_reset === 1'b1) both_cnt++;
            if (bus.out_start === 1'b1 && prev_start) wide_cnt++;
            if (bus.out_ball_reset === 1'b1 && prev_br) wide_cnt++;
        end
        prev_start = (bus.out_start === 1'b1);
        prev_br    = (bus.out_ball_reset === 1'b1);
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        tests++;
        assert (obs === want) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
        end
    endtask

    task automatic do_reset();
        int b0;
        rst = 1'b1;
        repeat (3) tick();
        chk("rst_state", bus.out_state, 0);
        chk("rst_left", bus.out_left_points, 0);
        chk("rst_right", bus.out_right_points, 0);
        chk("rst_start", bus.out_start, 0);
        chk("rst_game_over", bus.out_game_over, 0);
        chk("rst_winner", bus.out_winner, 0);
        exp_l = 0;
        exp_r = 0;
        b0 = br_cnt;
        rst = 1'b0;
        tick();
        chk("post_rst_ball_reset_hi", bus.out_ball_reset, 1);
        tick();
        chk("post_rst_ball_reset_lo", bus.out_ball_reset, 0);
        chk("post_rst_ball_reset_once", br_cnt - b0, 1);
    endtask

    task automatic serve_start();
        int n = 0;
        bus.in_serve = 1'b1;
        while (bus.out_start !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        chk("serve_latency", n, 2);
        chk("serve_state_play", bus.out_state, 2);
        tick();
        chk("start_one_cycle", bus.out_start, 0);
        bus.in_serve = 1'b0;
        tick();
    endtask

    task automatic run_delay(input int mode);
        int  s0, strobes, guard, g;
        bit  done;
        if (mode == 1) begin
            bus.in_left_score  = 1'b1;
            bus.in_right_score = 1'b1;
            bus.in_serve       = 1'b1;
            tick();
            tick();
            bus.in_left_score  = 1'b0;
            bus.in_right_score = 1'b0;
            bus.in_serve       = 1'b0;
            tick();
            chk("delay_ignore_state", bus.out_state, 3);
            chk("delay_ignore_left", bus.out_left_points, exp_l);
            chk("delay_ignore_right", bus.out_right_points, exp_r);
        end
        if (mode == 2) bus.in_right_score = 1'b1;
        s0      = start_cnt;
        strobes = 0;
        guard   = 0;
        done    = 1'b0;
        while (!done && guard < 2000) begin
            bus.in_ani_stb = 1'b1;
            tick();
            bus.in_ani_stb = 1'b0;
            strobes++;
            guard++;
            g = $urandom_range(1, 3);
            for (int i = 0; i < g; i++) begin
                tick();
                guard++;
                if (bus.out_start === 1'b1) done = 1'b1;
            end
        end
        tick();
        chk("delay_done", done, 1);
        chk("delay_strobes", strobes, SDLY);
        chk("delay_start_once", start_cnt - s0, 1);
        chk("delay_state_play", bus.out_state, 2);
        if (mode == 2) begin
            repeat (5) tick();
            chk("held_level_ignored", bus.out_right_points, exp_r);
            bus.in_right_score = 1'b0;
            tick();
        end
    endtask

    // side: 0 left, 1 right, 2 both in the same cycle
    task automatic score_point(input int side, input int hold, input int mode);
        if (side != 1) bus.in_left_score  = 1'b1;
        if (side != 0) bus.in_right_score = 1'b1;
        repeat (hold) tick();
        bus.in_left_score  = 1'b0;
        bus.in_right_score = 1'b0;
        tick();
        if (side != 1) exp_l++;
        else           exp_r++;
        chk("left_points", bus.out_left_points, exp_l);
        chk("right_points", bus.out_right_points, exp_r);
        if (exp_l == WIN || exp_r == WIN) begin
            chk("game_over", bus.out_game_over, 1);
            chk("winner", bus.out_winner, (exp_r == WIN) ? 1 : 0);
            chk("state_over", bus.out_state, 4);
        end else begin
            chk("state_delay", bus.out_state, 3);
            run_delay(mode);
        end
    endtask

    task automatic over_hold();
        int s0 = start_cnt;
        bus.in_left_score = 1'b1;
        tick();
        bus.in_left_score = 1'b0;
        bus.in_right_score = 1'b1;
        tick();
        bus.in_right_score = 1'b0;
        repeat (100) begin
            bus.in_ani_stb = 1'b1;
            tick();
            bus.in_ani_stb = 1'b0;
            tick();
            tick();
        end
        chk("over_no_start", start_cnt - s0, 0);
        chk("over_hold_left", bus.out_left_points, exp_l);
        chk("over_hold_right", bus.out_right_points, exp_r);
        chk("over_hold_game_over", bus.out_game_over, 1);
        chk("over_hold_state", bus.out_state, 4);
    endtask

    task automatic serve_over();
        int b0 = br_cnt;
        bus.in_serve = 1'b1;
        tick();
        chk("restart_ball_reset", bus.out_ball_reset, 1);
        chk("restart_state", bus.out_state, 0);
        chk("restart_game_over", bus.out_game_over, 0);
        chk("restart_left", bus.out_left_points, 0);
        chk("restart_right", bus.out_right_points, 0);
        tick();
        chk("restart_ball_reset_lo", bus.out_ball_reset, 0);
        bus.in_serve = 1'b0;
        tick();
        chk("restart_ball_reset_once", br_cnt - b0, 1);
        exp_l = 0;
        exp_r = 0;
    endtask

    initial begin
        int s0, it;
        bus.in_ani_stb     = 1'b0;
        bus.in_left_score  = 1'b0;
        bus.in_right_score = 1'b0;
        bus.in_serve       = 1'b0;

        do_reset();
        chk("idle_state", bus.out_state, 0);

        // first game: directed opening rallies, then random to the end
        serve_start();
        s0 = start_cnt;
        bus.in_serve = 1'b1;
        tick();
        tick();
        bus.in_serve = 1'b0;
        tick();
        chk("play_ignores_serve_state", bus.out_state, 2);
        chk("play_ignores_serve_start", start_cnt - s0, 0);

        score_point(0, 50, 1);
        score_point(2, 3, 2);
        it = 0;
        while (exp_l < WIN && exp_r < WIN && it < 40) begin
            score_point($urandom_range(0, 2), $urandom_range(1, 6), 0);
            it++;
        end
        chk("game1_finished", (exp_l == WIN || exp_r == WIN) ? 1 : 0, 1);
        over_hold();
        serve_over();

        // second game: right takes every rally
        serve_start();
        for (int k = 0; k < WIN; k++) begin
            score_point(1, $urandom_range(1, 8), 0);
        end
        chk("game2_right", bus.out_right_points, 5);
        chk("game2_left", bus.out_left_points, 0);
        chk("game2_winner_right", bus.out_winner, 1);
        over_hold();
        serve_over();

        // reset in the middle of DELAY with serve held high
        serve_start();
        bus.in_left_score = 1'b1;
        tick();
        bus.in_left_score = 1'b0;
        tick();
        chk("pre_rst_state_delay", bus.out_state, 3);
        repeat (30) begin
            bus.in_ani_stb = 1'b1;
            tick();
            bus.in_ani_stb = 1'b0;
            tick();
        end
        bus.in_serve = 1'b1;
        tick();
        do_reset();
        s0 = start_cnt;
        repeat (20) tick();
        chk("held_serve_no_start", start_cnt - s0, 0);
        chk("held_serve_idle", bus.out_state, 0);
        chk("held_serve_left", bus.out_left_points, 0);
        bus.in_serve = 1'b0;
        tick();
        serve_start();

        chk("no_coincident_pulses", both_cnt, 0);
        chk("pulse_width", wide_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
